// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM states,
// opcode values, ALU_decoder operation codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_LUI      = 4'd8,
    S_JAL      = 4'd9,
    S_ALUWB    = 4'd10,
    S_BRANCH   = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  // Supported instruction opcodes (IR[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // Operation class handed to ALU_decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  // Write-back / PC-next result source
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand A source
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU operand B source
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // True for ops that read two registers and write none
  function automatic logic is_store_or_branch(input logic [6:0] op);
    return (op == OP_SW) || (op == OP_B);
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_instr_decoder.sv
// Combinational opcode decoder: selects the immediate format for the
// extender and reports whether the opcode is one the core implements.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src,
  output logic       legal,
  output logic       no_rd
);

  // Map each supported opcode to its immediate format; anything else is illegal
  always_comb begin
    imm_src = IMM_I;
    legal   = 1'b0;
    case (op)
      OP_LW:  begin imm_src = IMM_I; legal = 1'b1; end
      OP_I:   begin imm_src = IMM_I; legal = 1'b1; end
      OP_SW:  begin imm_src = IMM_S; legal = 1'b1; end
      OP_B:   begin imm_src = IMM_B; legal = 1'b1; end
      OP_JAL: begin imm_src = IMM_J; legal = 1'b1; end
      OP_LUI: begin imm_src = IMM_U; legal = 1'b1; end
      OP_R:   begin imm_src = IMM_I; legal = 1'b1; end
      default: begin
        imm_src = IMM_I;
        legal   = 1'b0;
      end
    endcase
  end

  assign no_rd = is_store_or_branch(op);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core. Steps each instruction
// through fetch/decode/execute/memory/writeback, drives all datapath
// selects and enables, stalls on mem_ready and flags unsupported opcodes.
// Optional macro CTRL_PERF_CNT_EN adds cycle_cnt and instret_cnt counters.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_src,
  output logic        reg_write,
  output logic [1:0]  alu_op,
  output logic        illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  state_t state_q, state_d;
  state_t out_state;
  logic   illegal_q, illegal_d;
  logic   legal;
  logic   no_rd;
  logic   pc_update;
  logic   branch;
  logic   ir_en;
  logic   mem_write_en;
  logic   reg_write_en;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;
  logic        retire;
`endif

  instr_decoder u_instr_decoder (
    .op      (op),
    .imm_src (imm_src),
    .legal   (legal),
    .no_rd   (no_rd)
  );

  // Next-state selection, sticky illegal flag and optional counter updates
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!legal) begin
          state_d = S_ERROR;
        end else begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXECR;
            OP_I:         state_d = S_EXECI;
            OP_B:         state_d = S_BRANCH;
            OP_JAL:       state_d = S_JAL;
            OP_LUI:       state_d = S_LUI;
            default:      state_d = S_ERROR;
          endcase
        end
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
    if (state_d == S_ERROR) begin
      illegal_d = 1'b1;
    end
`ifdef CTRL_PERF_CNT_EN
    retire        = (state_d == S_FETCH) && (state_q != S_FETCH) &&
                    (state_q != S_ERROR);
    cycle_cnt_d   = cycle_cnt_q + 32'd1;
    instret_cnt_d = retire ? (instret_cnt_q + 32'd1) : instret_cnt_q;
`endif
  end

  // State register, sticky illegal flag and counters with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      illegal_q     <= 1'b0;
`ifdef CTRL_PERF_CNT_EN
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      illegal_q     <= illegal_d;
`ifdef CTRL_PERF_CNT_EN
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
`endif
    end
  end

  // Per-state datapath controls; reset presents fetch selects with enables idle
  always_comb begin
    out_state    = rst_n ? state_q : S_FETCH;
    adr_src      = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    alu_op       = ALUOP_ADD;
    pc_update    = 1'b0;
    branch       = 1'b0;
    ir_en        = 1'b0;
    mem_write_en = 1'b0;
    reg_write_en = 1'b0;
    case (out_state)
      S_FETCH: begin
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALURESULT;
        ir_en      = mem_ready;
        pc_update  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src   = RES_RDATA;
        reg_write_en = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src      = 1'b1;
        result_src   = RES_ALUOUT;
        mem_write_en = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_LUI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_PASS;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
      end
      S_ALUWB: begin
        result_src   = RES_ALUOUT;
        reg_write_en = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
      default: begin
        adr_src      = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        pc_update    = 1'b0;
        branch       = 1'b0;
        ir_en        = 1'b0;
        mem_write_en = 1'b0;
        reg_write_en = 1'b0;
      end
    endcase
  end

  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_en;
  assign mem_write = rst_n & mem_write_en;
  assign reg_write = rst_n & reg_write_en & ~(no_rd & (out_state == S_ALUWB));
  assign illegal   = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: a table of per-cycle
// {inputs, expected outputs} records plus hand-written corner sequences.
// Build with CTRL_PERF_CNT_EN defined to also check the counters.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_B   = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_BAD = 7'b1111111;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    outs_t      exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [6:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  imm_src;
  logic        reg_write;
  logic [1:0]  alu_op;
  logic        illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int   checks;
  int   errors;
  vec_t vecs[$];

  multicycle_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_src    (imm_src),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .illegal    (illegal)
`ifdef CTRL_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic outs_t mk(input logic pcw, input logic adr, input logic mw,
                               input logic irw, input logic [1:0] res,
                               input logic [1:0] a, input logic [1:0] b,
                               input logic [2:0] imm, input logic rw,
                               input logic [1:0] aop, input logic ill);
    outs_t o;
    o.pc_write   = pcw;
    o.adr_src    = adr;
    o.mem_write  = mw;
    o.ir_write   = irw;
    o.result_src = res;
    o.alu_src_a  = a;
    o.alu_src_b  = b;
    o.imm_src    = imm;
    o.reg_write  = rw;
    o.alu_op     = aop;
    o.illegal    = ill;
    return o;
  endfunction

  task automatic addVec(input logic r, input logic [6:0] o, input logic z,
                        input logic m, input outs_t e);
    vec_t v;
    v.rst_n     = r;
    v.op        = o;
    v.zero      = z;
    v.mem_ready = m;
    v.exp       = e;
    vecs.push_back(v);
  endtask

  // Inputs change half a cycle before the active edge; outputs settle by #1
  task automatic applyStimulus(input logic r, input logic [6:0] o,
                               input logic z, input logic m);
    @(negedge clk);
    rst_n     = r;
    op        = o;
    zero      = z;
    mem_ready = m;
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act.pc_write   = pc_write;
    act.adr_src    = adr_src;
    act.mem_write  = mem_write;
    act.ir_write   = ir_write;
    act.result_src = result_src;
    act.alu_src_a  = alu_src_a;
    act.alu_src_b  = alu_src_b;
    act.imm_src    = imm_src;
    act.reg_write  = reg_write;
    act.alu_op     = alu_op;
    act.illegal    = illegal;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s outputs actual=%05h required=%05h (pcw,adr,mw,irw,res2,a2,b2,imm3,rw,aop2,ill)",
               name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    op        = OPC_R;
    zero      = 1'b0;
    mem_ready = 1'b0;

    // R-type: FETCH, DECODE, EXECR, ALUWB
    addVec(1'b1, OPC_R, 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_R, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_R, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd0,1'b0,2'd2,1'b0));
    addVec(1'b1, OPC_R, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,1'b1,2'd0,1'b0));
    // lw with two wait cycles in MEMREAD: 7 cycles
    addVec(1'b1, OPC_LW, 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_LW, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_LW, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_LW, 1'b0, 1'b0, mk(1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_LW, 1'b0, 1'b0, mk(1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_LW, 1'b0, 1'b1, mk(1'b0,1'b1,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_LW, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd1,2'd0,2'd0,3'd0,1'b1,2'd0,1'b0));
    // sw with one fetch stall and one MEMWRITE stall
    addVec(1'b1, OPC_SW, 1'b0, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,3'd1,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_SW, 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd1,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_SW, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd1,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_SW, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd1,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_SW, 1'b0, 1'b0, mk(1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,3'd1,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_SW, 1'b0, 1'b1, mk(1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,3'd1,1'b0,2'd0,1'b0));
    // branch taken (zero=1 also held in DECODE, where pc_write must stay 0)
    addVec(1'b1, OPC_B, 1'b1, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd2,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_B, 1'b1, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd2,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_B, 1'b1, 1'b1, mk(1'b1,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd2,1'b0,2'd1,1'b0));
    // branch not taken
    addVec(1'b1, OPC_B, 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd2,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_B, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd2,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_B, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd0,3'd2,1'b0,2'd1,1'b0));
    // jal: pc_write in JAL, reg_write in ALUWB
    addVec(1'b1, OPC_JAL, 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd3,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_JAL, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd3,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_JAL, 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b0,2'd0,2'd1,2'd2,3'd3,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_JAL, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd3,1'b1,2'd0,1'b0));
    // lui: passthrough with U immediate
    addVec(1'b1, OPC_LUI, 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd4,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_LUI, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd4,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_LUI, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd1,3'd4,1'b0,2'd3,1'b0));
    addVec(1'b1, OPC_LUI, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd4,1'b1,2'd0,1'b0));
    // I-ALU
    addVec(1'b1, OPC_I, 1'b0, 1'b1, mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_I, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,1'b0,2'd0,1'b0));
    addVec(1'b1, OPC_I, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd2,2'd1,3'd0,1'b0,2'd2,1'b0));
    addVec(1'b1, OPC_I, 1'b0, 1'b1, mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,1'b1,2'd0,1'b0));
    // back in FETCH, stalled
    addVec(1'b1, OPC_R, 1'b0, 1'b0, mk(1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,3'd0,1'b0,2'd0,1'b0));

    // Initial reset: two cycles low, check after the first reset edge
    applyStimulus(1'b0, OPC_R, 1'b0, 1'b0);
    applyStimulus(1'b0, OPC_R, 1'b0, 1'b0);
    checkOutput("reset_hold", mk(1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,3'd0,1'b0,2'd0,1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].op, vecs[i].zero, vecs[i].mem_ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end
`ifdef CTRL_PERF_CNT_EN
    checkValue("cycle_cnt_table", cycle_cnt, vecs.size() - 1);
    checkValue("instret_cnt_table", instret_cnt, 32'd8);
`endif

    // Illegal opcode: sticky flag, no enables, retire count untouched
    applyStimulus(1'b1, OPC_BAD, 1'b0, 1'b1);
    checkOutput("bad_fetch", mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd0,1'b0,2'd0,1'b0));
    applyStimulus(1'b1, OPC_BAD, 1'b0, 1'b1);
    checkOutput("bad_decode", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd0,1'b0,2'd0,1'b0));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, OPC_BAD, 1'b1, 1'b1);
      checkOutput($sformatf("error_hold%0d", k), mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd0,2'd0,3'd0,1'b0,2'd0,1'b1));
    end
`ifdef CTRL_PERF_CNT_EN
    checkValue("instret_cnt_illegal", instret_cnt, 32'd8);
    checkValue("cycle_cnt_illegal", cycle_cnt, vecs.size() + 4);
`endif
    applyStimulus(1'b0, OPC_R, 1'b0, 1'b1);
    applyStimulus(1'b1, OPC_R, 1'b0, 1'b0);
    checkOutput("error_cleared", mk(1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,3'd0,1'b0,2'd0,1'b0));
`ifdef CTRL_PERF_CNT_EN
    checkValue("cycle_cnt_after_reset", cycle_cnt, 32'd0);
    checkValue("instret_cnt_after_reset", instret_cnt, 32'd0);
`endif

    // Reset during a stalled store: strobes forced low, then clean fetch
    applyStimulus(1'b1, OPC_SW, 1'b0, 1'b1);
    checkOutput("sw_fetch", mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd1,1'b0,2'd0,1'b0));
    applyStimulus(1'b1, OPC_SW, 1'b0, 1'b1);
    applyStimulus(1'b1, OPC_SW, 1'b0, 1'b1);
    applyStimulus(1'b1, OPC_SW, 1'b0, 1'b0);
    checkOutput("sw_stalled", mk(1'b0,1'b1,1'b1,1'b0,2'd0,2'd0,2'd0,3'd1,1'b0,2'd0,1'b0));
    applyStimulus(1'b0, OPC_SW, 1'b0, 1'b0);
    checkOutput("reset_in_memwrite", mk(1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,3'd1,1'b0,2'd0,1'b0));
    applyStimulus(1'b0, OPC_SW, 1'b0, 1'b1);
    checkOutput("reset_ready_masked", mk(1'b0,1'b0,1'b0,1'b0,2'd2,2'd0,2'd2,3'd1,1'b0,2'd0,1'b0));
    applyStimulus(1'b1, OPC_SW, 1'b0, 1'b1);
    checkOutput("fetch_after_reset", mk(1'b1,1'b0,1'b0,1'b1,2'd2,2'd0,2'd2,3'd1,1'b0,2'd0,1'b0));
    applyStimulus(1'b1, OPC_SW, 1'b0, 1'b1);
    checkOutput("decode_after_reset", mk(1'b0,1'b0,1'b0,1'b0,2'd0,2'd1,2'd1,3'd1,1'b0,2'd0,1'b0));
`ifdef CTRL_PERF_CNT_EN
    checkValue("cycle_cnt_restart", cycle_cnt, 32'd1);
    checkValue("instret_cnt_restart", instret_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control unit of the multicycle RV32I core; sits directly upstream of ALU_decoder and drives its alu_op input.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Generates all datapath mux selects and write enables.
- Stalls on a memory-ready handshake; flags unsupported opcodes.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (must remain S_FETCH; exposed for bench forcing only)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- op  input  7  instruction opcode, from IR[6:0]
- zero  input  1  ALU zero flag (branch resolution)
- mem_ready  input  1  memory completed the current access this cycle
- pc_write  output  1  PC load enable (pc_update | (branch & zero))
- adr_src  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR/OldPC load enable
- result_src  output  2  00 = ALUOut, 01 = read data, 10 = ALU result
- alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1
- alu_src_b  output  2  00 = rs2, 01 = imm, 10 = constant 4
- imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
- reg_write  output  1  register file write enable
- alu_op  output  2  to ALU_decoder: 00 add, 01 sub, 10 funct, 11 passthrough
- illegal  output  1  sticky unsupported-opcode flag

Behaviour:
- Single clock clk; synchronous active-low reset rst_n.
- Reset: state <= S_FETCH, illegal <= 0.
- While rst_n = 0, force pc_write, ir_write, mem_write and reg_write to 0. Other outputs take their S_FETCH values.
- Outputs are combinational from state and op; ready-gated strobes also depend on mem_ready. Unlisted outputs are 0.
- imm_src decodes op combinationally in every state: lw/I-ALU = 000, sw = 001, branch = 010, jal = 011, lui = 100.
- Supported opcodes: 0000011 lw, 0100011 sw, 0110011 R, 0010011 I-ALU, 1100011 branch, 1101111 jal, 0110111 lui.
- States, outputs and next state:
  - S_FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write=pc_update=mem_ready. Holds until mem_ready=1, then -> S_DECODE.
  - S_DECODE: a=01, b=01, alu_op=00 (branch/jal target into ALUOut). Next by op: lw/sw -> S_MEMADR; R -> S_EXECR; I -> S_EXECI; branch -> S_BRANCH; jal -> S_JAL; lui -> S_LUI; other -> S_ERROR.
  - S_MEMADR: a=10, b=01, alu_op=00. Next: lw -> S_MEMREAD, sw -> S_MEMWRITE.
  - S_MEMREAD: adr_src=1, result_src=00. Holds until mem_ready, then -> S_MEMWB.
  - S_MEMWB: result_src=01, reg_write=1 -> S_FETCH.
  - S_MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until mem_ready=1 (inclusive) -> S_FETCH.
  - S_EXECR: a=10, b=00, alu_op=10 -> S_ALUWB.
  - S_EXECI: a=10, b=01, alu_op=10 -> S_ALUWB.
  - S_LUI: b=01, alu_op=11 -> S_ALUWB.
  - S_JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1 -> S_ALUWB (writes PC+4).
  - S_ALUWB: result_src=00, reg_write=1 -> S_FETCH.
  - S_BRANCH: a=10, b=00, alu_op=01, result_src=00, branch=1 -> S_FETCH.
  - S_ERROR: all enables 0, illegal=1. Stays until reset.
- Latencies from entering S_FETCH, with zero-wait memory:
  - branch: 3 cycles
  - R, I-ALU, lui, jal, sw: 4 cycles
  - lw: 5 cycles
  - each mem_ready=0 cycle in S_FETCH, S_MEMREAD or S_MEMWRITE adds one cycle.
- pc_write = pc_update | (branch & zero); never asserted outside S_FETCH, S_JAL, S_BRANCH.
- Reset mid-instruction (any state, including a stalled access): next cycle is S_FETCH. No partial write-back; illegal cleared.
- State encoding is unconstrained, but unreachable encodings -> S_FETCH.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- Defined: adds output ports cycle_cnt [31:0] and instret_cnt [31:0].
  - Both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on each transition into S_FETCH from a non-fetch, non-error state.
  - Both wrap 0xFFFFFFFF -> 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_B, OP_JAL, OP_LUI)
  - alu_op constants shared with ALU_decoder (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, ALUOP_PASS=11)
  - mux-select constants for result_src, alu_src_a, alu_src_b, imm_src
- One natural sub-module: instr_decoder (combinational op -> imm_src and legal flag). State register and output logic stay in the top.

Test Plan:
- Reset: rst_n=0 for 2 cycles in S_MEMWRITE with mem_ready=0 -> mem_write=0 during reset; state S_FETCH after release; illegal=0.
- R-type add: op=0110011, mem_ready=1 -> FETCH, DECODE, EXECR (alu_op=10), ALUWB (reg_write=1) -> FETCH; 4 cycles.
- lw with 2-cycle wait in S_MEMREAD: mem_ready low 2 cycles -> reg_write pulses once in S_MEMWB; 7 cycles total.
- Branch: op=1100011, zero=1 -> pc_write=1 in S_BRANCH with alu_op=01. Same with zero=0 -> pc_write=0 in S_BRANCH.
- jal then lui: jal gives pc_write=1 in S_JAL, then reg_write in S_ALUWB. lui gives alu_op=11 and imm_src=100.
- Illegal op=1111111 -> S_ERROR, illegal=1 held, no enables; rst_n pulse clears it. With CTRL_PERF_CNT_EN, instret_cnt is unchanged by the illegal instruction.
